ldl_piso_serializer: RTL and testbench
======================================

Name: ldl_piso_serializer

Overview:
Parallel-in/serial-out word serializer. It accepts one LEVEL*WIDTH-bit word over a valid/ready handshake and emits it as LEVEL consecutive WIDTH-bit beats over a second valid/ready handshake. It is the transmit-side counterpart of the shift-left delay/collect array: that array's serial input, after LEVEL beats, reassembles the original word. It sits at width-conversion points between wide datapaths and narrow links.

Parameters:
WIDTH, 8, bits per output beat (>=1)
LEVEL, 4, beats per input word (>=1)
MSB_FIRST, 1, 1: first beat = in_data[LEVEL*WIDTH-1 -: WIDTH]; 0: first beat = in_data[WIDTH-1:0]

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  input word valid
in_ready  output  1  serializer can accept a word this cycle
in_data  input  LEVEL*WIDTH  parallel word
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts beat
out_data  output  WIDTH  current beat
out_last  output  1  current beat is beat LEVEL-1 of the word
busy  output  1  word held (same as out_valid)

Behaviour:
- Storage: shift register sreg[LEVEL*WIDTH-1:0], beat counter cnt of width max(1,$clog2(LEVEL)), flag out_valid. All outputs are driven from registers, except in_ready, which is combinational.
- Reset: out_valid=0, out_last=0, busy=0, cnt=0, sreg=0, so out_data=0. in_ready=1 from the first cycle after reset.
- States: EMPTY (out_valid=0) and SENDING (out_valid=1).
- in_ready = !out_valid | (out_ready & out_last). This gives zero-bubble back-to-back words. in_ready never depends on in_valid.
- Load (in_valid & in_ready):
  - sreg <= in_data, cnt <= 0, out_valid <= 1.
  - The first beat appears on out_data the following cycle. Latency is in-accept to first beat valid = 1 cycle.
- Beat transfer (out_valid & out_ready):
  - If not out_last: sreg shifts by WIDTH and cnt <= cnt+1. For MSB_FIRST=1 this is a left shift with zero fill; for MSB_FIRST=0 it is a right shift with zero fill.
  - If out_last and no simultaneous load: out_valid <= 0, and the state returns to EMPTY.
  - If out_last with a simultaneous load: the load wins (sreg reloaded, cnt=0, out_valid stays 1).
- out_data = sreg[LEVEL*WIDTH-1 -: WIDTH] when MSB_FIRST=1, else sreg[WIDTH-1:0].
- out_last = out_valid & (cnt == LEVEL-1).
- Backpressure: while out_valid & !out_ready, out_data, out_last, cnt and sreg hold stable (AXI-style; valid never deasserts without a transfer). in_ready=0 during this time.
- LEVEL=1: every beat is last. The block is then a one-deep registered pipeline stage with full throughput (one word per cycle under continuous out_ready).
- Throughput: with continuous in_valid and out_ready, exactly one beat is emitted every cycle, with no idle gaps between words.
- Reset mid-word: the remaining beats are discarded and out_valid=0 in the cycle after rst is sampled. No partial word is emitted after reset.
- rst has priority over load and shift in the same cycle.
- in_data is sampled only at load; changes to it while SENDING are ignored.

Test Plan:
- Basic MSB-first: WIDTH=8, LEVEL=4, out_ready=1, load 0xA1B2C3D4 at cycle 0 -> out_data A1, B2, C3, D4 on cycles 1..4; out_last=1 only on D4; in_ready=0 on cycles 1..3 and 1 on cycle 4; out_valid=0 on cycle 5.
- LSB-first: MSB_FIRST=0, same word -> beats D4, C3, B2, A1 in that order; out_last on A1.
- Back-to-back: in_valid held with words 0x11223344 then 0x55667788, out_ready=1 -> 8 consecutive valid beats 11,22,33,44,55,66,77,88 with no gap; second word accepted in the same cycle as beat 44.
- Backpressure: deassert out_ready for 3 cycles while beat B2 is shown -> B2 and out_last=0 stay stable, in_ready=0 throughout, and C3 follows the cycle after out_ready returns. Also change in_data during SENDING -> emitted beats unaffected.
- Reset mid-word: assert rst after beat B2 is accepted -> next cycle out_valid=0, in_ready=1, out_data=0; a new load 0xDEADBEEF then emits DE, AD, BE, EF.
- LEVEL=1, WIDTH=16: continuous in_valid with words 0x0001, 0x0002, 0x0003 -> one beat per cycle, each with out_last=1. Stalling out_ready for one cycle holds 0x0002 and drops in_ready for that cycle.

Source files
------------

// File: rtl/ldl_piso_serializer_if.sv
// ldl_piso_serializer_if: word-in / beat-out handshake bundle for the serializer.
interface ldl_piso_serializer_if #(
    parameter int WIDTH = 8,
    parameter int LEVEL = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LEVEL*WIDTH-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_last;
    logic                   busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/ldl_piso_serializer.sv
// ldl_piso_serializer: splits a LEVEL*WIDTH-bit word into LEVEL WIDTH-bit beats.
module ldl_piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int LEVEL     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic clk,
    input logic rst,
    ldl_piso_serializer_if.slave bus
);
    localparam int W  = LEVEL * WIDTH;
    localparam int CW = LEVEL > 1 ? $clog2(LEVEL) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(LEVEL - 1);
    localparam logic [0:0] EMPTY   = 1'b0;
    localparam logic [0:0] SENDING = 1'b1;

    logic [0:0]    state;
    logic [W-1:0]  sreg;
    logic [CW-1:0] cnt;
    logic          last;
    logic          load;
    logic          fire;

    assign load          = bus.in_valid & bus.in_ready;
    assign fire          = state == SENDING & bus.out_ready;
    // A word can enter while the final beat of the previous one leaves.
    assign bus.in_ready  = state == EMPTY | (bus.out_ready & last);
    assign bus.out_valid = state == SENDING;
    assign bus.busy      = state == SENDING;
    assign bus.out_last  = last;
    assign bus.out_data  = MSB_FIRST ? sreg[W-1 -: WIDTH] : sreg[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            sreg  <= '0;
            cnt   <= '0;
            last  <= 1'b0;
        end else if (load) begin
            state <= SENDING;
            sreg  <= bus.in_data;
            cnt   <= '0;
            last  <= LEVEL == 1;
        end else if (fire) begin
            if (last) begin
                state <= EMPTY;
                last  <= 1'b0;
            end else begin
                sreg <= MSB_FIRST ? sreg << WIDTH : sreg >> WIDTH;
                cnt  <= cnt + 1'b1;
                last <= cnt == LAST_CNT - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ldl_piso_serializer.sv
// tb_ldl_piso_serializer: MSB-first, LSB-first and LEVEL=1 serializers against a beat-queue model.
module tb_ldl_piso_serializer;
    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   go  = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    ldl_piso_serializer_if #(.WIDTH(8), .LEVEL(4)) ia ();
    ldl_piso_serializer_if #(.WIDTH(8), .LEVEL(4)) ib ();
    ldl_piso_serializer_if #(.WIDTH(16), .LEVEL(1)) ic ();

    ldl_piso_serializer #(.WIDTH(8), .LEVEL(4), .MSB_FIRST(1'b1)) ua (.clk(clk), .rst(rst), .bus(ia.slave));
    ldl_piso_serializer #(.WIDTH(8), .LEVEL(4), .MSB_FIRST(1'b0)) ub (.clk(clk), .rst(rst), .bus(ib.slave));
    ldl_piso_serializer #(.WIDTH(16), .LEVEL(1), .MSB_FIRST(1'b1)) uc (.clk(clk), .rst(rst), .bus(ic.slave));

    always #5 clk = ~clk;

    logic [31:0] fa[$], fb[$], fc[$];
    beat_t       qa[$], qb[$], qc[$];
    bit          acc_a, acc_b, acc_c;
    bit          gap_a, gap_b, gap_c;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction

    // Beat k of a word, taken straight from the word's bit layout.
    function automatic logic [15:0] beat(logic [31:0] w, int width, int level, bit msb, int k);
        int sh = msb ? width * (level - 1 - k) : width * k;
        logic [31:0] m = (32'd1 << width) - 32'd1;
        return 16'((w >> sh) & m);
    endfunction

    // Feeders: offer queued words, dropping a word only once it was accepted.
    initial forever begin
        @(posedge clk); #1;
        if (acc_a && fa.size() != 0) void'(fa.pop_front());
        if (acc_b && fb.size() != 0) void'(fb.pop_front());
        if (acc_c && fc.size() != 0) void'(fc.pop_front());
        ia.in_valid = fa.size() != 0 && !gap_a;
        ib.in_valid = fb.size() != 0 && !gap_b;
        ic.in_valid = fc.size() != 0 && !gap_c;
        ia.in_data  = fa.size() != 0 ? fa[0] : $urandom;
        ib.in_data  = fb.size() != 0 ? fb[0] : $urandom;
        ic.in_data  = fc.size() != 0 ? fc[0][15:0] : 16'($urandom);
    end

    // Monitors: outputs at negedge must match the pending-beat queue; then advance the model.
    initial forever begin
        @(negedge clk);
        acc_a = 1'b0;
        if (go) begin
            chk("a_valid", ia.out_valid, qa.size() != 0);
            chk("a_busy", ia.busy, qa.size() != 0);
            chk("a_in_ready", ia.in_ready, qa.size() == 0 || (ia.out_ready && qa.size() == 1));
            if (qa.size() != 0) begin
                chk("a_data", ia.out_data, qa[0].d);
                chk("a_last", ia.out_last, qa[0].l);
            end else chk("a_last_idle", ia.out_last, 0);
            acc_a = ia.in_valid & ia.in_ready;
            if (rst) qa.delete();
            else begin
                if (ia.out_valid && ia.out_ready && qa.size() != 0) void'(qa.pop_front());
                if (acc_a) for (int k = 0; k < 4; k++) qa.push_back('{beat(ia.in_data, 8, 4, 1'b1, k), k == 3});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        acc_b = 1'b0;
        if (go) begin
            chk("b_valid", ib.out_valid, qb.size() != 0);
            chk("b_in_ready", ib.in_ready, qb.size() == 0 || (ib.out_ready && qb.size() == 1));
            if (qb.size() != 0) begin
                chk("b_data", ib.out_data, qb[0].d);
                chk("b_last", ib.out_last, qb[0].l);
            end
            acc_b = ib.in_valid & ib.in_ready;
            if (rst) qb.delete();
            else begin
                if (ib.out_valid && ib.out_ready && qb.size() != 0) void'(qb.pop_front());
                if (acc_b) for (int k = 0; k < 4; k++) qb.push_back('{beat(ib.in_data, 8, 4, 1'b0, k), k == 3});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        acc_c = 1'b0;
        if (go) begin
            chk("c_valid", ic.out_valid, qc.size() != 0);
            chk("c_in_ready", ic.in_ready, qc.size() == 0 || (ic.out_ready && qc.size() == 1));
            if (qc.size() != 0) begin
                chk("c_data", ic.out_data, qc[0].d);
                chk("c_last", ic.out_last, qc[0].l);
            end
            acc_c = ic.in_valid & ic.in_ready;
            if (rst) qc.delete();
            else begin
                if (ic.out_valid && ic.out_ready && qc.size() != 0) void'(qc.pop_front());
                if (acc_c) qc.push_back('{beat(32'(ic.in_data), 16, 1, 1'b1, 0), 1'b1});
            end
        end
    end

    task automatic wait_show(int inst, logic [15:0] v);
        logic [15:0] d;
        logic        vl;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            d  = inst == 0 ? 16'(ia.out_data) : 16'(ic.out_data);
            vl = inst == 0 ? ia.out_valid : ic.out_valid;
            if (vl && d == v) return;
        end
        chk("wait_timeout", 0, 1);
    endtask

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        ia.out_ready = 1'b1; ib.out_ready = 1'b1; ic.out_ready = 1'b1;
        ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0;
        ia.in_data = '0; ib.in_data = '0; ic.in_data = '0;
        @(posedge clk); #1;
        go = 1'b1;
        cycles(2);
        rst = 1'b0;
        @(negedge clk);
        chk("a_rst_data", ia.out_data, 0);
        chk("b_rst_data", ib.out_data, 0);
        chk("c_rst_data", ic.out_data, 0);
        chk("a_rst_ready", ia.in_ready, 1);
        cycles(1);
        // Single word both orders, then back-to-back words, LEVEL=1 stream.
        fa.push_back(32'hA1B2C3D4); fb.push_back(32'hA1B2C3D4);
        fc.push_back(32'h0001); fc.push_back(32'h0002); fc.push_back(32'h0003);
        cycles(8);
        fa.push_back(32'h11223344); fa.push_back(32'h55667788);
        fb.push_back(32'h11223344); fb.push_back(32'h55667788);
        cycles(12);
        // Backpressure on B2 while in_data wanders.
        fa.push_back(32'hA1B2C3D4);
        wait_show(0, 16'hB2);
        ia.out_ready = 1'b0;
        cycles(3);
        chk("a_hold_data", ia.out_data, 32'hB2);
        chk("a_hold_last", ia.out_last, 0);
        ia.out_ready = 1'b1;
        cycles(6);
        // Reset after B2 has been taken.
        fa.push_back(32'hA1B2C3D4);
        wait_show(0, 16'hC3);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        chk("a_midrst_valid", ia.out_valid, 0);
        chk("a_midrst_ready", ia.in_ready, 1);
        chk("a_midrst_data", ia.out_data, 0);
        cycles(1);
        fa.push_back(32'hDEADBEEF);
        cycles(7);
        // LEVEL=1 one-cycle stall on 0x0002.
        fc.push_back(32'h0001); fc.push_back(32'h0002); fc.push_back(32'h0003);
        wait_show(1, 16'h0002);
        ic.out_ready = 1'b0;
        @(negedge clk);
        chk("c_stall_ready", ic.in_ready, 0);
        cycles(1);
        ic.out_ready = 1'b1;
        cycles(4);
        // Random traffic, backpressure and occasional resets.
        for (int i = 0; i < 600; i++) begin
            ia.out_ready = $urandom_range(0, 3) != 0;
            ib.out_ready = $urandom_range(0, 1) != 0;
            ic.out_ready = $urandom_range(0, 3) != 0;
            gap_a = $urandom_range(0, 4) == 0;
            gap_b = $urandom_range(0, 2) == 0;
            gap_c = $urandom_range(0, 4) == 0;
            rst = $urandom_range(0, 79) == 0;
            if (fa.size() < 2) fa.push_back($urandom);
            if (fb.size() < 2) fb.push_back($urandom);
            if (fc.size() < 2) fc.push_back($urandom);
            cycles(1);
        end
        rst = 1'b0;
        gap_a = 1'b0; gap_b = 1'b0; gap_c = 1'b0;
        ia.out_ready = 1'b1; ib.out_ready = 1'b1; ic.out_ready = 1'b1;
        cycles(30);
        @(negedge clk);
        chk("a_drained", qa.size(), 0);
        chk("b_drained", qb.size(), 0);
        chk("c_drained", qc.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
